mem_arbiter: RTL

- Shares one single-port, fixed-latency unified memory between the CPU's instruction-fetch path and its load/store path.
- Runs one access at a time, with round-robin priority when both sides request in the same cycle.
- Returns registered read data and a one-cycle valid pulse to the requester that owns the access.
- Drives a stall signal that freezes the CPU's program counter and register-file writes until the access completes.

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port, fixed-latency memory between the instruction-fetch path (if_*)
//   and the load/store path (d_*). One access is in flight at a time; simultaneous requests
//   alternate through a round-robin last-owner flag. Read data and a one-cycle valid pulse
//   are registered back to the owning side, and cpu_stall holds the CPU until its access
//   completes.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   if_req/if_addr        fetch request and address
//   if_gnt                fetch accepted this cycle (combinational)
//   if_valid/if_rdata     registered fetch completion pulse and instruction word
//   d_req/d_we/d_addr/d_wdata  load/store request
//   d_gnt                 data request accepted this cycle (combinational)
//   d_valid/d_rdata       registered completion pulse; load data, 0 for stores
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobe and command (combinational)
//   mem_rdata             memory read data, valid MEM_LATENCY cycles after mem_en
//   busy                  an access is in flight
//   cpu_stall             a request is outstanding and not completing this cycle
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_rdata,

  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_valid,
  output logic [DATA_WIDTH-1:0] d_rdata,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,

  output logic                  busy,
  output logic                  cpu_stall
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam logic [3:0] CntInit  = 4'(MEM_LATENCY - 1);
  // With a single-cycle memory the data is already valid in the cycle after the grant.
  localparam bit         SkipWait = (MEM_LATENCY <= 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  owner_q, owner_d;            // 1 = data side owns the access
  logic                  owner_we_q, owner_we_d;      // owning access is a store
  logic                  last_owner_q, last_owner_d;  // 1 = data side was granted last
  logic                  if_valid_q, if_valid_d;
  logic                  d_valid_q, d_valid_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic idle;
  logic grant_if;
  logic grant_d;

  // Reset also masks the combinational outputs so every output reads 0 while rst is low,
  // even with requests held high.
  assign idle     = (state_q == StIdle) && rst;
  assign grant_if = idle && if_req && (!d_req || last_owner_q);
  assign grant_d  = idle && d_req && (!if_req || !last_owner_q);

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign mem_en    = grant_if || grant_d;
  assign mem_we    = grant_d && d_we;
  assign mem_addr  = grant_d ? d_addr : (grant_if ? if_addr : '0);
  assign mem_wdata = grant_d ? d_wdata : '0;

  assign busy      = (state_q != StIdle);
  assign cpu_stall = rst && ((if_req && !if_valid_q) || (d_req && !d_valid_q));

  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    owner_we_d   = owner_we_q;
    last_owner_d = last_owner_q;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_if || grant_d) begin
          owner_d      = grant_d;
          last_owner_d = grant_d;
          owner_we_d   = grant_d && d_we;
          cnt_d        = CntInit;
          state_d      = SkipWait ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        // mem_rdata is valid in this cycle; the pulse appears in the following IDLE cycle.
        state_d = StIdle;
        cnt_d   = 4'd0;
        if (owner_q) begin
          d_valid_d = 1'b1;
          d_rdata_d = owner_we_q ? '0 : mem_rdata;
        end else begin
          if_valid_d = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      owner_q      <= 1'b0;
      owner_we_q   <= 1'b0;
      last_owner_q <= 1'b1;  // first tie goes to fetch
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      owner_we_q   <= owner_we_d;
      last_owner_q <= last_owner_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

endmodule
